// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared command/state types and reset-point helper for the LCD image controller
package lcd_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE       = 4'd0,
    CMD_UP          = 4'd1,
    CMD_DOWN        = 4'd2,
    CMD_LEFT        = 4'd3,
    CMD_RIGHT       = 4'd4,
    CMD_AVG         = 4'd5,
    CMD_MIRROR_X    = 4'd6,
    CMD_MIRROR_Y    = 4'd7,
    CMD_MAX         = 4'd8,
    CMD_MIN         = 4'd9,
    CMD_ROT_CW      = 4'd10,
    CMD_ROT_CCW     = 4'd11,
    CMD_RELOAD      = 4'd12,
    CMD_RESET_POINT = 4'd13
  } cmd_e;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_IDLE  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  // Top-left pixel of the 2x2 window sitting on the image centre.
  function automatic int reset_point(input int img_w, input int img_h);
    return (img_h / 2 - 1) * img_w + (img_w / 2 - 1);
  endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// rtl/lcd_win_alu.sv - combinational 2x2 window operator (average, max, min, mirror, rotate)
module lcd_win_alu
  import lcd_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    cmd,
  input  logic [DW-1:0] px_a,
  input  logic [DW-1:0] px_b,
  input  logic [DW-1:0] px_c,
  input  logic [DW-1:0] px_d,
  output logic [DW-1:0] new_a,
  output logic [DW-1:0] new_b,
  output logic [DW-1:0] new_c,
  output logic [DW-1:0] new_d,
  output logic          wr_en
);

  logic [DW+1:0] sum;
  logic [DW-1:0] avg;
  logic [DW-1:0] max_ab, max_cd, win_max;
  logic [DW-1:0] min_ab, min_cd, win_min;

  always_comb begin
    sum     = {2'b00, px_a} + {2'b00, px_b} + {2'b00, px_c} + {2'b00, px_d};
    avg     = sum[DW+1:2];
    max_ab  = (px_a > px_b) ? px_a : px_b;
    max_cd  = (px_c > px_d) ? px_c : px_d;
    win_max = (max_ab > max_cd) ? max_ab : max_cd;
    min_ab  = (px_a < px_b) ? px_a : px_b;
    min_cd  = (px_c < px_d) ? px_c : px_d;
    win_min = (min_ab < min_cd) ? min_ab : min_cd;
  end

  // Window layout is [a b; c d] with a at the operation point.
  always_comb begin
    new_a = px_a;
    new_b = px_b;
    new_c = px_c;
    new_d = px_d;
    wr_en = 1'b1;
    case (cmd)
      CMD_AVG:      begin new_a = avg;     new_b = avg;     new_c = avg;     new_d = avg;     end
      CMD_MIRROR_X: begin new_a = px_c;    new_b = px_d;    new_c = px_a;    new_d = px_b;    end
      CMD_MIRROR_Y: begin new_a = px_b;    new_b = px_a;    new_c = px_d;    new_d = px_c;    end
      CMD_MAX:      begin new_a = win_max; new_b = win_max; new_c = win_max; new_d = win_max; end
      CMD_MIN:      begin new_a = win_min; new_b = win_min; new_c = win_min; new_d = win_min; end
      CMD_ROT_CW:   begin new_a = px_c;    new_b = px_a;    new_c = px_d;    new_d = px_b;    end
      CMD_ROT_CCW:  begin new_a = px_b;    new_b = px_d;    new_c = px_a;    new_d = px_c;    end
      default:      wr_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// rtl/lcd_ctrl_gen.sv - image buffer controller: IROM load, 2x2 window commands, IRB write-out
module lcd_ctrl_gen
  import lcd_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8,
  parameter int AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_EN,
  output logic [AW-1:0] IROM_A,
  output logic          IRB_RW,
  output logic [DW-1:0] IRB_D,
  output logic [AW-1:0] IRB_A,
  output logic          busy,
  output logic          done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = $clog2(IMG_W);
  localparam int RB = AW - CW;

  localparam logic [AW-1:0] LAST    = AW'(N - 1);
  localparam logic [AW-1:0] RST_P   = AW'(reset_point(IMG_W, IMG_H));
  localparam logic [AW-1:0] STEP_W  = AW'(IMG_W);
  localparam logic [AW-1:0] ONE     = AW'(1);
  localparam logic [RB-1:0] ROW_MAX = RB'(IMG_H - 2);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 2);

  state_e state_q, state_d;

  logic [DW-1:0] buffer [N];
  logic [AW-1:0] point;
  logic [3:0]    cmd_q;
  logic [AW-1:0] rd_addr;
  logic          q_valid;
  logic          load_last;
  logic [AW-1:0] irb_next;

  logic [RB-1:0] row;
  logic [CW-1:0] col;

  logic [AW-1:0] addr_a, addr_b, addr_c, addr_d;
  logic [DW-1:0] px_a, px_b, px_c, px_d;
  logic [DW-1:0] new_a, new_b, new_c, new_d;
  logic          alu_we;

  assign row       = point[AW-1:CW];
  assign col       = point[CW-1:0];
  assign addr_a    = point;
  assign addr_b    = point + ONE;
  assign addr_c    = point + STEP_W;
  assign addr_d    = point + STEP_W + ONE;
  assign px_a      = buffer[addr_a];
  assign px_b      = buffer[addr_b];
  assign px_c      = buffer[addr_c];
  assign px_d      = buffer[addr_d];
  assign irb_next  = IRB_A + ONE;
  // rd_addr is the address whose ROM data is on IROM_Q this cycle.
  assign load_last = (state_q == S_LOAD) && q_valid && (rd_addr == LAST);

  lcd_win_alu #(.DW(DW)) u_alu (
    .cmd   (cmd_q),
    .px_a  (px_a),
    .px_b  (px_b),
    .px_c  (px_c),
    .px_d  (px_d),
    .new_a (new_a),
    .new_b (new_b),
    .new_c (new_c),
    .new_d (new_d),
    .wr_en (alu_we)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (load_last) state_d = S_IDLE;
      S_IDLE:  if (cmd_valid && !busy) state_d = S_EXEC;
      S_EXEC: begin
        if (cmd_q == CMD_WRITE)       state_d = S_WRITE;
        else if (cmd_q == CMD_RELOAD) state_d = S_LOAD;
        else                          state_d = S_IDLE;
      end
      S_WRITE: if (IRB_A == LAST) state_d = S_IDLE;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b1;
      done    <= 1'b0;
      IROM_EN <= 1'b0;
      IROM_A  <= '0;
      IRB_RW  <= 1'b1;
      IRB_A   <= '0;
      IRB_D   <= '0;
      point   <= RST_P;
      cmd_q   <= '0;
      rd_addr <= '0;
      q_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_LOAD: begin
          rd_addr <= IROM_A;
          q_valid <= 1'b1;
          if (IROM_A != LAST) IROM_A <= IROM_A + ONE;
          if (load_last) begin
            IROM_EN <= 1'b1;
            busy    <= 1'b0;
            q_valid <= 1'b0;
          end
        end
        S_IDLE: begin
          if (cmd_valid && !busy) begin
            cmd_q <= cmd;
            busy  <= 1'b1;
          end
        end
        S_EXEC: begin
          busy <= 1'b0;
          case (cmd_q)
            CMD_WRITE: begin
              busy   <= 1'b1;
              IRB_RW <= 1'b0;
              IRB_A  <= '0;
              IRB_D  <= buffer[0];
            end
            CMD_UP:          if (row != '0)      point <= point - STEP_W;
            CMD_DOWN:        if (row < ROW_MAX)  point <= point + STEP_W;
            CMD_LEFT:        if (col != '0)      point <= point - ONE;
            CMD_RIGHT:       if (col < COL_MAX)  point <= point + ONE;
            CMD_RESET_POINT: point <= RST_P;
            CMD_RELOAD: begin
              busy    <= 1'b1;
              IROM_EN <= 1'b0;
              IROM_A  <= '0;
              q_valid <= 1'b0;
            end
            default: ;
          endcase
        end
        S_WRITE: begin
          if (IRB_A == LAST) begin
            IRB_RW <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            IRB_A <= irb_next;
            IRB_D <= buffer[irb_next];
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer holds image data only; its contents are irrelevant until a load completes.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && q_valid) begin
      buffer[rd_addr] <= IROM_Q;
    end else if (state_q == S_EXEC && alu_we) begin
      buffer[addr_a] <= new_a;
      buffer[addr_b] <= new_b;
      buffer[addr_c] <= new_c;
      buffer[addr_d] <= new_d;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// tb/tb_lcd_ctrl_gen.sv - self-checking bench for lcd_ctrl_gen (vector table + random vs reference model)
module tb_lcd_ctrl_gen;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [7:0] IROM_Q;
  logic       IROM_EN;
  logic [5:0] IROM_A;
  logic       IRB_RW;
  logic [7:0] IRB_D;
  logic [5:0] IRB_A;
  logic       busy;
  logic       done;

  lcd_ctrl_gen #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .IROM_Q    (IROM_Q),
    .IROM_EN   (IROM_EN),
    .IROM_A    (IROM_A),
    .IRB_RW    (IRB_RW),
    .IRB_D     (IRB_D),
    .IRB_A     (IRB_A),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [N];
  always @(posedge clk) if (!IROM_EN) IROM_Q <= rom[IROM_A];

  int n_cmp;
  int n_bad;
  int mbuf [N];
  int mr, mc;
  logic [7:0] dumpv [N];

  typedef struct {
    logic [3:0]      cmd;
    int              rep;
    bit              chk;
    logic [3:0][5:0] addr;
    logic [3:0][7:0] val;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(input int c, input int rep, input int chk,
                              input int a0, input int a1, input int a2, input int a3,
                              input int v0, input int v1, input int v2, input int v3);
    vec_t v;
    v.cmd = 4'(c);
    v.rep = rep;
    v.chk = (chk != 0);
    v.addr[0] = 6'(a0); v.addr[1] = 6'(a1); v.addr[2] = 6'(a2); v.addr[3] = 6'(a3);
    v.val[0]  = 8'(v0); v.val[1]  = 8'(v1); v.val[2]  = 8'(v2); v.val[3]  = 8'(v3);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic void put4(input int base, input int na, input int nb, input int nc, input int nd);
    mbuf[base] = na; mbuf[base+1] = nb; mbuf[base+W] = nc; mbuf[base+W+1] = nd;
  endfunction

  // Reference: window [a b; c d] at row mr, column mc.
  function automatic void model_cmd(input int c);
    int base, a, b, x, d, m;
    base = mr * W + mc;
    a = mbuf[base]; b = mbuf[base+1]; x = mbuf[base+W]; d = mbuf[base+W+1];
    case (c)
      1:  if (mr > 0) mr--;
      2:  if (mr < H - 2) mr++;
      3:  if (mc > 0) mc--;
      4:  if (mc < W - 2) mc++;
      5:  begin m = (a + b + x + d) / 4; put4(base, m, m, m, m); end
      6:  put4(base, x, d, a, b);
      7:  put4(base, b, a, d, x);
      8:  begin
            m = a;
            if (b > m) m = b;
            if (x > m) m = x;
            if (d > m) m = d;
            put4(base, m, m, m, m);
          end
      9:  begin
            m = a;
            if (b < m) m = b;
            if (x < m) m = x;
            if (d < m) m = d;
            put4(base, m, m, m, m);
          end
      10: put4(base, x, a, d, b);
      11: put4(base, b, d, a, x);
      12: for (int i = 0; i < N; i++) mbuf[i] = int'(rom[i]);
      13: begin mr = H / 2 - 1; mc = W / 2 - 1; end
      default: ;
    endcase
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("wait_idle_timeout", 32'(t < 300), 32'd1);
  endtask

  task automatic send_cmd(input int c);
    wait_idle();
    cmd = 4'(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    model_cmd(c);
  endtask

  task automatic do_write();
    int t;
    bit seq_ok;
    send_cmd(0);
    t = 0;
    while (IRB_RW !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("write_start_latency", t, 1);
    seq_ok = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (IRB_RW !== 1'b0 || IRB_A !== 6'(k) || busy !== 1'b1 || done !== 1'b0) seq_ok = 1'b0;
      dumpv[k] = IRB_D;
      @(negedge clk);
    end
    check("write_seq", seq_ok, 1);
    check("done_pulse", done, 1);
    check("write_end_rw", IRB_RW, 1);
    check("write_end_busy", busy, 0);
    @(negedge clk);
    check("done_width", done, 0);
    for (int k = 0; k < N; k++) check($sformatf("pixel[%0d]", k), dumpv[k], mbuf[k]);
  endtask

  // Asserts reset at the current negedge, checks the reset outputs, then times the load.
  task automatic reset_and_load();
    int e;
    bit sweep_ok;
    reset = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_irom_en", IROM_EN, 0);
    check("rst_irom_a", IROM_A, 0);
    check("rst_irb_rw", IRB_RW, 1);
    check("rst_irb_a", IRB_A, 0);
    check("rst_irb_d", IRB_D, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    e = 0;
    sweep_ok = 1'b1;
    do begin
      @(negedge clk);
      e++;
      if (e <= N && (IROM_A !== 6'(e > N - 1 ? N - 1 : e) || IROM_EN !== 1'b0 || busy !== 1'b1))
        sweep_ok = 1'b0;
    end while (busy !== 1'b0 && e < 200);
    check("load_latency", e, N + 1);
    check("irom_sweep", sweep_ok, 1);
    check("irom_en_after_load", IROM_EN, 1);
    for (int i = 0; i < N; i++) mbuf[i] = int'(rom[i]);
    mr = H / 2 - 1;
    mc = W / 2 - 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, n;
    n_cmp = 0;
    n_bad = 0;
    cmd = '0;
    cmd_valid = 1'b0;
    for (int i = 0; i < N; i++) rom[i] = 8'(i);

    vecs[0]  = mk(5,  1, 1, 27, 28, 35, 36, 31, 31, 31, 31);
    vecs[1]  = mk(1,  8, 0,  0,  0,  0,  0,  0,  0,  0,  0);
    vecs[2]  = mk(5,  1, 1,  3,  4, 11, 12,  7,  7,  7,  7);
    vecs[3]  = mk(4, 10, 0,  0,  0,  0,  0,  0,  0,  0,  0);
    vecs[4]  = mk(5,  1, 1,  6,  7, 14, 15, 10, 10, 10, 10);
    vecs[5]  = mk(13, 1, 0,  0,  0,  0,  0,  0,  0,  0,  0);
    vecs[6]  = mk(3,  5, 0,  0,  0,  0,  0,  0,  0,  0,  0);
    vecs[7]  = mk(1,  4, 0,  0,  0,  0,  0,  0,  0,  0,  0);
    vecs[8]  = mk(10, 1, 1,  0,  1,  8,  9,  8,  0,  9,  1);
    vecs[9]  = mk(9,  1, 1,  0,  1,  8,  9,  0,  0,  0,  0);
    vecs[10] = mk(2, 10, 0,  0,  0,  0,  0,  0,  0,  0,  0);
    vecs[11] = mk(8,  1, 1, 48, 49, 56, 57, 57, 57, 57, 57);
    vecs[12] = mk(4, 10, 0,  0,  0,  0,  0,  0,  0,  0,  0);
    vecs[13] = mk(6,  1, 1, 54, 55, 62, 63, 62, 63, 54, 55);
    vecs[14] = mk(7,  1, 1, 54, 55, 62, 63, 63, 62, 55, 54);
    vecs[15] = mk(11, 1, 1, 54, 55, 62, 63, 62, 54, 63, 55);
    vecs[16] = mk(14, 1, 1, 54, 55, 62, 63, 62, 54, 63, 55);

    @(negedge clk);
    reset_and_load();

    for (int i = 0; i < NV; i++) begin
      for (int r = 0; r < vecs[i].rep; r++) send_cmd(int'(vecs[i].cmd));
      if (vecs[i].chk) begin
        do_write();
        for (int j = 0; j < 4; j++)
          check($sformatf("vec%0d_px%0d", i, vecs[i].addr[j]), dumpv[vecs[i].addr[j]], vecs[i].val[j]);
      end
    end
    do_write();

    // cmd_valid held high: accepted only on every other edge.
    send_cmd(13);
    wait_idle();
    cmd = 4'd4;
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("hold_busy_%0d", i), busy, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) model_cmd(4);
    end
    cmd_valid = 1'b0;
    send_cmd(5);
    do_write();

    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < N; i++) rom[i] = 8'($urandom_range(0, 255));
      send_cmd(12);
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("reload_latency", n, N + 2);
      for (int j = 0; j < 25; j++) begin
        c = int'($urandom_range(1, 15));
        if (c == 12) for (int i = 0; i < N; i++) rom[i] = 8'($urandom_range(0, 255));
        send_cmd(c);
      end
      do_write();
    end

    // Reset in the middle of a write-out at k=20.
    send_cmd(0);
    n = 0;
    while (!(IRB_RW === 1'b0 && IRB_A === 6'd20) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_k20", IRB_A, 20);
    reset_and_load();
    send_cmd(5);
    do_write();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
